fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Fetch-stage controller: owns the program counter, issues single-outstanding
//  instruction-memory requests, and presents one fetched instruction at a time to
//  decode. Arbitrates PC source (boot, sequential +4, redirect from EX) against
//  the hazard-unit stall. Sits between imem and the IF/ID boundary.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  BOOT_DELAY  4              run_en-high cycles to wait in IDLE before the first fetch (0..15)
// PORTS
//  clk             in   1   clock
//  reset           in   1   synchronous, active-high
//  run_en          in   1   global fetch enable
//  stall           in   1   decode cannot accept; holds if_valid/if_pc/if_instr
//  redirect_valid  in   1   taken branch/jump from EX
//  redirect_addr   in   32  redirect target
//  imem_req        out  1   request valid
//  imem_addr       out  32  request address, word aligned
//  imem_ready      in   1   imem accepts request this cycle
//  imem_rvalid     in   1   read data valid, >=1 cycle after accept
//  imem_rdata      in   32  read data
//  if_valid        out  1   instruction presented to decode
//  if_pc           out  32  PC of the presented instruction
//  if_instr        out  32  presented instruction
//  flush_if        out  1   one-cycle pulse: presented/in-flight fetch discarded
// BEHAVIOUR
//  - Clock clk; reset is synchronous, active-high. On reset: state=IDLE,
//    pc_q=RESET_PC, boot_cnt=BOOT_DELAY, kill=0, imem_req=0, imem_addr=RESET_PC,
//    if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), flush_if=0. Reset wins over all inputs.
//  - imem_addr = pc_q always; imem_req = (state==REQ) & run_en (combinational).
//  - IDLE: while run_en, boot_cnt decrements each cycle, saturating at 0;
//    boot_cnt==0 & run_en -> REQ. boot_cnt is reloaded only by reset.
//  - REQ: run_en=0 -> IDLE. imem_ready -> WAIT; fetch_pc<=pc_q.
//  - WAIT: on imem_rvalid: if kill, discard data, kill<=0 -> REQ; otherwise
//    if_valid<=1, if_pc<=fetch_pc, if_instr<=imem_rdata, pc_q<=fetch_pc+4
//    (mod 2^32, wraps FFFF_FFFC->0) -> HOLD.
//  - HOLD: consumption = if_valid & ~stall. On consumption, if_valid<=0 -> REQ.
//    While stall, if_valid/if_pc/if_instr are held stable.
//  - Redirect, any state except during reset: pc_q<={redirect_addr[31:2],2'b00};
//    overrides the +4 update and stall.
//      IDLE: stay IDLE.
//      REQ, no imem_ready: stay REQ; new address is driven next cycle.
//      REQ with imem_ready in the same cycle: accepted request is stale -> WAIT, kill<=1.
//      WAIT: kill<=1. If rvalid occurs in the same cycle, the data is dropped.
//      HOLD: if_valid<=0 -> REQ.
//    flush_if<=1 for one cycle whenever a valid instruction or an in-flight request is discarded.
//  - At most one imem request is outstanding. Throughput: 1 instr per 3 cycles
//    with single-cycle imem.
//  - run_en low in WAIT/HOLD: the current fetch completes; the machine then parks in IDLE at REQ.
// STRUCTURE
//  - Shared package: state encoding (IDLE/REQ/WAIT/HOLD), NOP constant 32'h13,
//    XLEN=32, RESET_PC default.
//  - One combinational sub-module, fetch_pc_sel: next-pc mux with priority
//    reset > redirect > sequential > hold. The FSM and output register stay in fetch_sequencer.
// TESTING
//  1 Boot: reset, then run_en=1, BOOT_DELAY=4 -> first imem_req in cycle 5
//    with addr 0; with ready/rvalid=1, if_pc=0,4,8 presented in order.
//  2 Stall: stall=1 for 5 cycles while if_valid -> if_pc/if_instr stable and
//    no imem_req; stall=0 -> next req addr = if_pc+4.
//  3 Redirect in WAIT: rvalid delayed 3 cycles, redirect 0x100 -> flush_if
//    pulse, returned data dropped, next req addr 0x100.
//  4 Redirect with imem_ready in the same REQ cycle: addr 0x20 accepted, target
//    0x200 -> 0x20 data dropped, next req 0x200. Misaligned 0x203 is fetched as 0x200.
//  5 Wrap: RESET_PC=32'hFFFF_FFFC -> second fetch addr 0.
//  6 Reset mid-WAIT, with rvalid arriving the next cycle -> outputs return to
//    reset values, data ignored, boot delay restarts.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch stage: state encoding, data width,
// reset address default and the NOP presented while nothing is fetched.
package fetch_sequencer_pkg;

   localparam int XLEN       = 32;
   localparam int BOOT_CNT_W = 4;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [XLEN-1:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the signals the fetch stage exchanges with imem, decode and EX.
// master is the fetch sequencer itself; slave is everything around it.
interface fetch_sequencer_if;
   import fetch_sequencer_pkg::*;

   logic            stall;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_addr;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;

   logic            if_valid;
   logic [XLEN-1:0] if_pc;
   logic [XLEN-1:0] if_instr;
   logic            flush_if;

   modport master (
      input  stall, redirect_valid, redirect_addr,
      input  imem_ready, imem_rvalid, imem_rdata,
      output imem_req, imem_addr,
      output if_valid, if_pc, if_instr, flush_if
   );

   modport slave (
      output stall, redirect_valid, redirect_addr,
      output imem_ready, imem_rvalid, imem_rdata,
      input  imem_req, imem_addr,
      input  if_valid, if_pc, if_instr, flush_if
   );

endinterface

// File: rtl/fetch_sequencer_pc_sel.sv
// Next program-counter selection. Reset beats a redirect, a redirect beats
// the sequential step after a completed fetch, otherwise the PC holds.
module fetch_pc_sel
   import fetch_sequencer_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            i_reset,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_addr,
   input  logic            i_seq_en,
   input  logic [XLEN-1:0] i_fetch_pc,
   input  logic [XLEN-1:0] i_pc_q,
   output logic [XLEN-1:0] o_pc_next
);

   // Priority mux; redirect targets are forced to word alignment and the
   // sequential step wraps naturally at the top of the address space.
   always_comb begin
      o_pc_next = i_pc_q;
      if (i_reset) begin
         o_pc_next = RESET_PC;
      end else if (i_redirect_valid) begin
         o_pc_next = i_redirect_addr & WORD_ALIGN_MASK;
      end else if (i_seq_en) begin
         o_pc_next = i_fetch_pc + 32'd4;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, keeps at most one imem request in
// flight, and presents one fetched instruction at a time to decode.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned     BOOT_DELAY = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_run_en,
   fetch_sequencer_if.master bus
);

   localparam logic [BOOT_CNT_W-1:0] BOOT_INIT = BOOT_CNT_W'(BOOT_DELAY);

   fetch_state_e          r_state;
   fetch_state_e          w_state_next;
   logic [XLEN-1:0]       r_pc_q;
   logic [XLEN-1:0]       r_fetch_pc;
   logic [BOOT_CNT_W-1:0] r_boot_cnt;
   logic                  r_kill;
   logic                  r_if_valid;
   logic [XLEN-1:0]       r_if_pc;
   logic [XLEN-1:0]       r_if_instr;
   logic                  r_flush_if;

   logic [XLEN-1:0]       w_pc_next;
   logic [BOOT_CNT_W-1:0] w_boot_cnt_next;
   logic                  w_kill_next;
   logic                  w_flush_next;
   logic                  w_accept;
   logic                  w_capture;
   logic                  w_clear_valid;
   logic                  w_consume;

   assign w_consume = r_if_valid & ~bus.stall;

   fetch_pc_sel #(
      .RESET_PC (RESET_PC)
   ) u_pc_sel (
      .i_reset          (reset),
      .i_redirect_valid (bus.redirect_valid),
      .i_redirect_addr  (bus.redirect_addr),
      .i_seq_en         (w_capture),
      .i_fetch_pc       (r_fetch_pc),
      .i_pc_q           (r_pc_q),
      .o_pc_next        (w_pc_next)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and control decode; a redirect always wins over stall and
   // marks whatever request is still outstanding as stale via kill.
   always_comb begin
      w_state_next    = r_state;
      w_boot_cnt_next = r_boot_cnt;
      w_kill_next     = r_kill;
      w_flush_next    = 1'b0;
      w_accept        = 1'b0;
      w_capture       = 1'b0;
      w_clear_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_run_en) begin
               if (r_boot_cnt == '0) begin
                  w_state_next = ST_REQ;
               end else begin
                  w_boot_cnt_next = r_boot_cnt - 1'b1;
               end
            end
         end
         ST_REQ: begin
            if (!i_run_en) begin
               w_state_next = ST_IDLE;
            end else if (bus.imem_ready) begin
               w_accept     = 1'b1;
               w_state_next = ST_WAIT;
               if (bus.redirect_valid) begin
                  w_kill_next  = 1'b1;
                  w_flush_next = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (bus.redirect_valid) begin
               w_flush_next = 1'b1;
               if (bus.imem_rvalid) begin
                  w_kill_next  = 1'b0;
                  w_state_next = ST_REQ;
               end else begin
                  w_kill_next = 1'b1;
               end
            end else if (bus.imem_rvalid) begin
               w_state_next = r_kill ? ST_REQ : ST_HOLD;
               w_kill_next  = 1'b0;
               w_capture    = ~r_kill;
            end
         end
         ST_HOLD: begin
            if (bus.redirect_valid) begin
               w_clear_valid = 1'b1;
               w_flush_next  = 1'b1;
               w_state_next  = ST_REQ;
            end else if (w_consume) begin
               w_clear_valid = 1'b1;
               w_state_next  = ST_REQ;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Program counter; its reset value comes through the selection mux.
   always_ff @(posedge clk) begin
      r_pc_q <= w_pc_next;
   end

   // Fetch bookkeeping and the instruction register presented to decode.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_boot_cnt <= BOOT_INIT;
         r_kill     <= 1'b0;
         r_fetch_pc <= RESET_PC;
         r_if_valid <= 1'b0;
         r_if_pc    <= '0;
         r_if_instr <= NOP_INSTR;
         r_flush_if <= 1'b0;
      end else begin
         r_boot_cnt <= w_boot_cnt_next;
         r_kill     <= w_kill_next;
         r_flush_if <= w_flush_next;
         if (w_accept) begin
            r_fetch_pc <= r_pc_q;
         end
         if (w_capture) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_fetch_pc;
            r_if_instr <= bus.imem_rdata;
         end else if (w_clear_valid) begin
            r_if_valid <= 1'b0;
         end
      end
   end

   assign bus.imem_req  = (r_state == ST_REQ) & i_run_en;
   assign bus.imem_addr = r_pc_q;
   assign bus.if_valid  = r_if_valid;
   assign bus.if_pc     = r_if_pc;
   assign bus.if_instr  = r_if_instr;
   assign bus.flush_if  = r_flush_if;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for the fetch sequencer: boot delay, sequential fetch,
// stall hold, redirects in WAIT/REQ/HOLD, PC wrap and reset mid-fetch.
module tb_fetch_sequencer;

   logic clk;
   logic reset;
   logic run_en;
   logic run_en1;

   int testsRun;
   int testsFailed;

   localparam logic [31:0] I0 = 32'h0010_0093;
   localparam logic [31:0] I1 = 32'h0020_0113;
   localparam logic [31:0] I2 = 32'h0030_0193;
   localparam logic [31:0] I3 = 32'h0040_0213;
   localparam logic [31:0] I4 = 32'h0050_0293;
   localparam logic [31:0] I5 = 32'h0060_0313;
   localparam logic [31:0] I6 = 32'h0070_0393;

   fetch_sequencer_if bus0 ();
   fetch_sequencer_if bus1 ();

   fetch_sequencer #(
      .RESET_PC   (32'h0000_0000),
      .BOOT_DELAY (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .i_run_en (run_en),
      .bus      (bus0)
   );

   fetch_sequencer #(
      .RESET_PC   (32'hFFFF_FFFC),
      .BOOT_DELAY (0)
   ) dutWrap (
      .clk      (clk),
      .reset    (reset),
      .i_run_en (run_en1),
      .bus      (bus1)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] time limit reached");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic run, input logic stl, input logic rdy,
                                input logic rv, input logic [31:0] rdata,
                                input logic redir, input logic [31:0] raddr);
      run_en              = run;
      bus0.stall          = stl;
      bus0.imem_ready     = rdy;
      bus0.imem_rvalid    = rv;
      bus0.imem_rdata     = rdata;
      bus0.redirect_valid = redir;
      bus0.redirect_addr  = raddr;
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      reset       = 1'b1;
      run_en1     = 1'b0;
      bus1.stall          = 1'b0;
      bus1.imem_ready     = 1'b0;
      bus1.imem_rvalid    = 1'b0;
      bus1.imem_rdata     = '0;
      bus1.redirect_valid = 1'b0;
      bus1.redirect_addr  = '0;
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
      tick(2);

      // Reset values
      checkOutput("rst_if_valid", {31'b0, bus0.if_valid}, 32'h0);
      checkOutput("rst_if_pc",    bus0.if_pc,             32'h0);
      checkOutput("rst_if_instr", bus0.if_instr,          32'h0000_0013);
      checkOutput("rst_flush",    {31'b0, bus0.flush_if}, 32'h0);
      checkOutput("rst_req",      {31'b0, bus0.imem_req}, 32'h0);
      checkOutput("rst_addr",     bus0.imem_addr,         32'h0);
      checkOutput("rst_addr_wrap", bus1.imem_addr,        32'hFFFF_FFFC);

      // Boot: four counting cycles, request appears after the fifth edge
      reset = 1'b0;
      applyStimulus(1, 0, 1, 1, I0, 0, 32'h0);
      tick(4);
      checkOutput("boot_no_req", {31'b0, bus0.imem_req}, 32'h0);
      tick(1);
      checkOutput("boot_req",      {31'b0, bus0.imem_req}, 32'h1);
      checkOutput("boot_req_addr", bus0.imem_addr,         32'h0);
      tick(1);
      checkOutput("wait_no_req", {31'b0, bus0.imem_req}, 32'h0);
      tick(1);
      checkOutput("f0_valid", {31'b0, bus0.if_valid}, 32'h1);
      checkOutput("f0_pc",    bus0.if_pc,             32'h0);
      checkOutput("f0_instr", bus0.if_instr,          I0);
      applyStimulus(1, 0, 1, 1, I1, 0, 32'h0);
      tick(1);
      checkOutput("f1_consumed", {31'b0, bus0.if_valid}, 32'h0);
      checkOutput("f1_req",      {31'b0, bus0.imem_req}, 32'h1);
      checkOutput("f1_addr",     bus0.imem_addr,         32'h4);
      tick(2);
      checkOutput("f1_pc",    bus0.if_pc,    32'h4);
      checkOutput("f1_instr", bus0.if_instr, I1);
      applyStimulus(1, 0, 1, 1, I2, 0, 32'h0);
      tick(3);
      checkOutput("f2_pc",    bus0.if_pc,    32'h8);
      checkOutput("f2_instr", bus0.if_instr, I2);

      // Stall: presented instruction held, no new request
      applyStimulus(1, 1, 1, 1, 32'hBADB_AD00, 0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         checkOutput("stall_valid", {31'b0, bus0.if_valid}, 32'h1);
         checkOutput("stall_pc",    bus0.if_pc,             32'h8);
         checkOutput("stall_instr", bus0.if_instr,          I2);
         checkOutput("stall_req",   {31'b0, bus0.imem_req}, 32'h0);
      end
      applyStimulus(1, 0, 1, 1, I3, 0, 32'h0);
      tick(1);
      checkOutput("unstall_req",  {31'b0, bus0.imem_req}, 32'h1);
      checkOutput("unstall_addr", bus0.imem_addr,         32'hC);
      tick(2);
      checkOutput("f3_pc",    bus0.if_pc,    32'hC);
      checkOutput("f3_instr", bus0.if_instr, I3);

      // Redirect while waiting on a slow read
      applyStimulus(1, 0, 1, 0, I3, 0, 32'h0);
      tick(1);
      checkOutput("slow_req_addr", bus0.imem_addr, 32'h10);
      tick(2);
      checkOutput("slow_wait_valid", {31'b0, bus0.if_valid}, 32'h0);
      applyStimulus(1, 0, 1, 0, I3, 1, 32'h0000_0100);
      tick(1);
      checkOutput("rdw_flush", {31'b0, bus0.flush_if}, 32'h1);
      checkOutput("rdw_addr",  bus0.imem_addr,         32'h100);
      checkOutput("rdw_req",   {31'b0, bus0.imem_req}, 32'h0);
      applyStimulus(1, 0, 1, 1, 32'hDEAD_0000, 0, 32'h0);
      tick(1);
      checkOutput("rdw_flush_end", {31'b0, bus0.flush_if}, 32'h0);
      checkOutput("rdw_dropped",   {31'b0, bus0.if_valid}, 32'h0);
      checkOutput("rdw_req",       {31'b0, bus0.imem_req}, 32'h1);
      checkOutput("rdw_next_addr", bus0.imem_addr,         32'h100);
      applyStimulus(1, 0, 1, 1, I4, 0, 32'h0);
      tick(2);
      checkOutput("f4_pc",    bus0.if_pc,    32'h100);
      checkOutput("f4_instr", bus0.if_instr, I4);

      // Redirect from HOLD, then redirect coinciding with imem_ready
      applyStimulus(1, 0, 1, 1, I4, 1, 32'h0000_0020);
      tick(1);
      checkOutput("rdh_flush", {31'b0, bus0.flush_if}, 32'h1);
      checkOutput("rdh_valid", {31'b0, bus0.if_valid}, 32'h0);
      checkOutput("rdh_req",   {31'b0, bus0.imem_req}, 32'h1);
      checkOutput("rdh_addr",  bus0.imem_addr,         32'h20);
      applyStimulus(1, 0, 1, 1, I4, 1, 32'h0000_0203);
      tick(1);
      checkOutput("rdr_flush", {31'b0, bus0.flush_if}, 32'h1);
      checkOutput("rdr_addr",  bus0.imem_addr,         32'h200);
      checkOutput("rdr_req",   {31'b0, bus0.imem_req}, 32'h0);
      applyStimulus(1, 0, 1, 1, 32'hBAD0_0020, 0, 32'h0);
      tick(1);
      checkOutput("rdr_flush_end", {31'b0, bus0.flush_if}, 32'h0);
      checkOutput("rdr_dropped",   {31'b0, bus0.if_valid}, 32'h0);
      checkOutput("rdr_req",       {31'b0, bus0.imem_req}, 32'h1);
      checkOutput("rdr_next_addr", bus0.imem_addr,         32'h200);
      applyStimulus(1, 0, 1, 1, I5, 0, 32'h0);
      tick(2);
      checkOutput("f5_pc",    bus0.if_pc,    32'h200);
      checkOutput("f5_instr", bus0.if_instr, I5);

      // Reset while waiting, read data arriving right after
      applyStimulus(1, 0, 1, 0, I5, 0, 32'h0);
      tick(2);
      reset = 1'b1;
      tick(1);
      checkOutput("mrst_valid", {31'b0, bus0.if_valid}, 32'h0);
      checkOutput("mrst_pc",    bus0.if_pc,             32'h0);
      checkOutput("mrst_instr", bus0.if_instr,          32'h0000_0013);
      checkOutput("mrst_req",   {31'b0, bus0.imem_req}, 32'h0);
      checkOutput("mrst_addr",  bus0.imem_addr,         32'h0);
      reset = 1'b0;
      applyStimulus(1, 0, 1, 1, 32'hBEEF_0000, 0, 32'h0);
      tick(1);
      checkOutput("mrst_ignored", {31'b0, bus0.if_valid}, 32'h0);
      checkOutput("mrst_instr2",  bus0.if_instr,          32'h0000_0013);
      tick(3);
      checkOutput("mrst_boot_no_req", {31'b0, bus0.imem_req}, 32'h0);
      tick(1);
      checkOutput("mrst_boot_req",  {31'b0, bus0.imem_req}, 32'h1);
      checkOutput("mrst_boot_addr", bus0.imem_addr,         32'h0);

      // PC wrap on the second instance (no boot delay)
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
      run_en1          = 1'b1;
      bus1.imem_ready  = 1'b1;
      bus1.imem_rvalid = 1'b1;
      bus1.imem_rdata  = I6;
      tick(1);
      checkOutput("wrap_req",  {31'b0, bus1.imem_req}, 32'h1);
      checkOutput("wrap_addr", bus1.imem_addr,         32'hFFFF_FFFC);
      tick(2);
      checkOutput("wrap_pc",    bus1.if_pc,    32'hFFFF_FFFC);
      checkOutput("wrap_instr", bus1.if_instr, I6);
      tick(1);
      checkOutput("wrap_req2",  {31'b0, bus1.imem_req}, 32'h1);
      checkOutput("wrap_addr2", bus1.imem_addr,         32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
